// File: rtl/mult_pkg.sv
// Shared constants and width helpers for the Mitchell multiplier pipeline.
package mult_pkg;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Bits needed for a leading-one position 0..w-1.
  function automatic int k_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Bits needed for a summed characteristic plus one carry step (up to 2w-1).
  function automatic int kk_width(input int w);
    return k_width(w) + 1;
  endfunction

endpackage

// File: rtl/mitch_lod.sv
// Combinational leading-one detector: position of the highest set bit and
// a flag for an all-zero operand (position reads 0 in that case).
module mitch_lod
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]          a,
  output logic [k_width(WIDTH)-1:0] pos,
  output logic                      zero
);

  localparam int KW = k_width(WIDTH);

  // Scan upward so the last set bit seen (the highest) wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) pos = KW'(i);
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/mitch_mult_pipe.sv
// Three-stage Mitchell logarithmic multiplier with a per-transaction exact
// mode. S1 registers operands, S2 holds log-domain values (or the exact
// product), S3 is the antilog result register. One global stall freezes
// every stage when the output is held by the consumer.
module mitch_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TRUNC = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p_out
);

  localparam int KW  = k_width(WIDTH);
  localparam int KKW = kk_width(WIDTH);
  localparam int PW  = 2 * WIDTH;

  // Pipeline-wide advance: bubbles at the output never block the pipe.
  logic advance;
  logic run;
  logic accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && run;
  assign accept   = in_valid && in_ready;

  // Stage 1 registers.
  logic             s1_valid;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;

  // Stage 2 registers.
  logic             s2_valid;
  logic             s2_mode;
  logic             s2_zero;
  logic [KW-1:0]    s2_kx;
  logic [KW-1:0]    s2_ky;
  logic [TRUNC-1:0] s2_mx;
  logic [TRUNC-1:0] s2_my;
  logic [PW-1:0]    s2_prod;

  // Log-domain combinational values for S2.
  logic [KW-1:0]    kx;
  logic [KW-1:0]    ky;
  logic             zx;
  logic             zy;
  logic [KW-1:0]    shx;
  logic [KW-1:0]    shy;
  logic [TRUNC-1:0] mx;
  logic [TRUNC-1:0] my;

  mitch_lod #(.WIDTH(WIDTH)) u_lod_x (.a(s1_x), .pos(kx), .zero(zx));
  mitch_lod #(.WIDTH(WIDTH)) u_lod_y (.a(s1_y), .pos(ky), .zero(zy));

  // Left-align so the leading one sits at the MSB; the cast drops that one
  // and the shift keeps the TRUNC fraction bits just below it (floor).
  assign shx = KW'(WIDTH - 1) - kx;
  assign shy = KW'(WIDTH - 1) - ky;
  assign mx  = TRUNC'((s1_x << shx) >> (WIDTH - 1 - TRUNC));
  assign my  = TRUNC'((s1_y << shy) >> (WIDTH - 1 - TRUNC));

  // Antilog combinational values for S3.
  logic [KKW-1:0]   kk;
  logic [TRUNC:0]   msum;
  logic             carry;
  logic [TRUNC:0]   mant;
  logic [KKW-1:0]   sh;
  logic [PW-1:0]    approx;

  assign kk    = KKW'(s2_kx) + KKW'(s2_ky);
  assign msum  = {1'b0, s2_mx} + {1'b0, s2_my};
  assign carry = msum[TRUNC];
  // Without carry the mantissa is 1.M; with carry the sum itself reads as
  // 1.f and the exponent gains one.
  assign mant  = carry ? msum : {1'b1, msum[TRUNC-1:0]};
  assign sh    = kk + KKW'(carry);
  // Mantissa is scaled by 2^TRUNC; shifting back right drops sub-unit bits.
  assign approx = PW'(({{PW{1'b0}}, mant} << sh) >> TRUNC);

  // Input acceptance is held off for one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Stage 1: capture operands and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_APPROX;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_mode  <= mode;
      s1_x     <= x;
      s1_y     <= y;
    end
  end

  // Stage 2: characteristics, truncated fractions, zero flag, exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= MODE_APPROX;
      s2_zero  <= 1'b0;
      s2_kx    <= '0;
      s2_ky    <= '0;
      s2_mx    <= '0;
      s2_my    <= '0;
      s2_prod  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_zero  <= zx || zy;
      s2_kx    <= kx;
      s2_ky    <= ky;
      s2_mx    <= mx;
      s2_my    <= my;
      s2_prod  <= PW'(s1_x) * PW'(s1_y);
    end
  end

  // Stage 3: select exact or antilog result into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_out     <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_mode == MODE_EXACT) p_out <= s2_prod;
      else if (s2_zero)          p_out <= '0;
      else                       p_out <= approx;
    end
  end

endmodule

// File: tb/tb_mitch_mult_pipe.sv
// Scoreboard bench for mitch_mult_pipe (WIDTH=16, TRUNC=5): a driver pushes
// expected products on accept, a monitor pops and compares on delivery.
module tb_mitch_mult_pipe;
  localparam int W = 16;
  localparam int T = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] p_out;

  typedef struct {
    logic [2*W-1:0] p;
    int             c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cmp = 0;
  bit   check_lat = 1'b0;
  bit   chk_ready = 1'b0;
  int   ready_mode = 0;

  mitch_mult_pipe #(.WIDTH(W), .TRUNC(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .p_out(p_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Mitchell reference from the number-theoretic definition:
  // x = 2^k (1 + f), f floored to T bits; P = 2^(kx+ky) (1 + fx + fy) when
  // fx+fy < 1, else 2^(kx+ky+1) (fx + fy); fractional part discarded.
  function automatic longint model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic m);
    int ka, kb;
    longint fa, fb, msum, kk;
    if (m) return longint'(a) * longint'(b);
    if (a == 0 || b == 0) return 0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = ((longint'(a) - (longint'(1) << ka)) << T) >> ka;
    fb = ((longint'(b) - (longint'(1) << kb)) << T) >> kb;
    msum = fa + fb;
    kk = ka + kb;
    if (msum < (longint'(1) << T)) return (((longint'(1) << T) + msum) << kk) >> T;
    return (msum << (kk + 1)) >> T;
  endfunction

  // Offer one operand pair; entered and left at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input logic [2*W-1:0] e);
    int  t;
    bit  ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    x = a;
    y = b;
    mode = m;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      t++;
      if (t > 200) break;
      @(posedge clk);
      #1;
    end
    if (ok) begin
      q.push_back('{p: e, c: cyc});
      n_vec++;
      $display("in  #%0d x=%0d y=%0d mode=%0d expect=%0d", n_vec, a, b, m, e);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_pending", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer: always ready, random ready, or held off.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: delivery scoreboard, stall stability, in_ready relation.
  initial begin
    bit             prev_stall;
    logic [2*W-1:0] prev_p;
    exp_t           e;
    prev_stall = 1'b0;
    prev_p = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", p_out, prev_p);
      end
      if (chk_ready) check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got p_out=%0d, required no output", p_out);
        end else begin
          e = q.pop_front();
          $display("out p=%0d expect=%0d latency=%0d", p_out, e.p, cyc - e.c);
          check("product", p_out, e.p);
          if (check_lat) check("latency", cyc - e.c, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p = p_out;
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [W-1:0] a, b;
    logic         m;
    int           seen;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_p_out", p_out, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);
    chk_ready = 1'b1;
    check_lat = 1'b1;

    // Known points of the approximation and both modes at full scale.
    send(16'd3,     16'd3,     1'b0, 32'd8);
    send(16'd5,     16'd6,     1'b0, 32'd28);
    send(16'd16,    16'd16,    1'b0, 32'd256);
    send(16'd3,     16'd1,     1'b0, 32'd3);
    send(16'd0,     16'd1234,  1'b0, 32'd0);
    send(16'd65535, 16'd65535, 1'b0, 32'd4160749568);
    send(16'd65535, 16'd65535, 1'b1, 32'd4294836225);

    // Back-to-back stream, alternating mode, consumer always ready.
    for (int i = 0; i < 100; i++) begin
      a = (i % 17 == 5) ? '0 : W'($urandom);
      b = W'($urandom);
      m = i[0];
      send(a, b, m, 32'(model(a, b, m)));
    end
    drain();

    // Random back-pressure and random gaps between offers.
    check_lat = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      b = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
      m = 1'($urandom_range(0, 1));
      send(a, b, m, 32'(model(a, b, m)));
      idle($urandom_range(0, 2));
    end
    ready_mode = 0;
    drain();

    // Fill the pipe with three results while the consumer is held off,
    // then reset asynchronously.
    ready_mode = 2;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom) | 16'd1;
      b = W'($urandom) | 16'd1;
      send(a, b, 1'b1, 32'(model(a, b, 1'b1)));
    end
    check("preload_out_valid", out_valid, 1);
    chk_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_p_out", p_out, 0);
    q.delete();
    idle(2);
    rst_n = 1'b1;
    ready_mode = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_reset_silent", seen, 0);
    @(posedge clk);
    #1;
    chk_ready = 1'b1;
    check_lat = 1'b1;

    // The pipe keeps working after the flush.
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      m = 1'($urandom_range(0, 1));
      send(a, b, m, 32'(model(a, b, m)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
